// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-style 8-bit CPU control sequencer:
// opcode values, T-state numbers, control-word bit positions and the FSM state type.
// No ports (package).
package sap_pkg;

   localparam int OPCODE_W = 4;
   localparam int STEP_W   = 3;

   // Instruction opcodes (IR upper nibble); 1001..1101 are undefined and decode as NOP
   localparam logic [OPCODE_W-1:0] OP_NOP = 4'b0000;
   localparam logic [OPCODE_W-1:0] OP_LDA = 4'b0001;
   localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0010;
   localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0011;
   localparam logic [OPCODE_W-1:0] OP_STA = 4'b0100;
   localparam logic [OPCODE_W-1:0] OP_LDI = 4'b0101;
   localparam logic [OPCODE_W-1:0] OP_JMP = 4'b0110;
   localparam logic [OPCODE_W-1:0] OP_JC  = 4'b0111;
   localparam logic [OPCODE_W-1:0] OP_JZ  = 4'b1000;
   localparam logic [OPCODE_W-1:0] OP_OUT = 4'b1110;
   localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

   // T-states: T0/T1 fetch, T2..T4 execute
   localparam logic [STEP_W-1:0] T0 = 3'd0;
   localparam logic [STEP_W-1:0] T1 = 3'd1;
   localparam logic [STEP_W-1:0] T2 = 3'd2;
   localparam logic [STEP_W-1:0] T3 = 3'd3;
   localparam logic [STEP_W-1:0] T4 = 3'd4;

   // Control-word bit positions
   localparam int CW_W   = 16;
   localparam int CW_LP  = 0;
   localparam int CW_EP  = 1;
   localparam int CW_CP  = 2;
   localparam int CW_OI  = 3;
   localparam int CW_FI  = 4;
   localparam int CW_SU  = 5;
   localparam int CW_EO  = 6;
   localparam int CW_BI  = 7;
   localparam int CW_AO  = 8;
   localparam int CW_AI  = 9;
   localparam int CW_IO  = 10;
   localparam int CW_II  = 11;
   localparam int CW_RO  = 12;
   localparam int CW_RI  = 13;
   localparam int CW_MI  = 14;
   localparam int CW_HLT = 15;

   typedef logic [CW_W-1:0] ctrl_word_t;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } seq_state_t;

endpackage

// File: rtl/sap_step_counter.sv
// T-state counter: advances on run, wraps at NUM_STEPS, holds while frozen, sync reset to T0.
// Ports: clk_i, rst_i (sync, active-high), run_i (advance enable), freeze_i (hold, halt path),
//        step_o (current T-state, registered).
module sap_step_counter
   import sap_pkg::*;
#(
   parameter int NUM_STEPS = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              run_i,
   input  logic              freeze_i,
   output logic [STEP_W-1:0] step_o
);

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

   logic [STEP_W-1:0] step_q;
   logic [STEP_W-1:0] step_d;

   always_comb begin
      step_d = step_q;
      if (run_i && !freeze_i) begin
         step_d = (step_q == LAST_STEP) ? '0 : step_q + STEP_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) step_q <= '0;
      else       step_q <= step_d;
   end

   assign step_o = step_q;

endmodule

// File: rtl/sap_control_sequencer.sv
// Control sequencer: RUN/HALT state plus combinational microcode decode of {state, step, opcode, flags}.
// Ports: clk_i, rst_i (sync, active-high), run_i, opcode_i, carry_flag_i, zero_flag_i in;
//        step_o, hlt_o and one output per control strobe (mi ri ro ii io ai ao bi eo su fi oi cp ep lp).
module sap_control_sequencer
   import sap_pkg::*;
#(
   parameter int NUM_STEPS = 5
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                run_i,
   input  logic [OPCODE_W-1:0] opcode_i,
   input  logic                carry_flag_i,
   input  logic                zero_flag_i,
   output logic [STEP_W-1:0]   step_o,
   output logic                hlt_o,
   output logic                mi_o,
   output logic                ri_o,
   output logic                ro_o,
   output logic                ii_o,
   output logic                io_o,
   output logic                ai_o,
   output logic                ao_o,
   output logic                bi_o,
   output logic                eo_o,
   output logic                su_o,
   output logic                fi_o,
   output logic                oi_o,
   output logic                cp_o,
   output logic                ep_o,
   output logic                lp_o
);

   seq_state_t        state_q;
   seq_state_t        state_d;
   logic [STEP_W-1:0] step_q;
   ctrl_word_t        ucode;
   ctrl_word_t        cw;

   // Counter must not advance on the HLT edge, so the step stays parked at T2.
   sap_step_counter #(.NUM_STEPS(NUM_STEPS)) u_step (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .run_i    (run_i),
      .freeze_i (cw[CW_HLT]),
      .step_o   (step_q)
   );

   always_comb begin
      ucode = '0;
      if (state_q == ST_HALT) begin
         ucode[CW_HLT] = 1'b1;
      end else if (run_i) begin
         unique case (step_q)
            T0: begin ucode[CW_EP] = 1'b1; ucode[CW_MI] = 1'b1; end
            T1: begin ucode[CW_RO] = 1'b1; ucode[CW_II] = 1'b1; ucode[CW_CP] = 1'b1; end
            T2: begin
               unique case (opcode_i)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     ucode[CW_IO] = 1'b1; ucode[CW_MI] = 1'b1;
                  end
                  OP_LDI: begin ucode[CW_IO] = 1'b1; ucode[CW_AI] = 1'b1; end
                  OP_JMP: begin ucode[CW_IO] = 1'b1; ucode[CW_LP] = 1'b1; end
                  // Conditional jumps look at the flags only here in T2
                  OP_JC:  begin ucode[CW_IO] = carry_flag_i; ucode[CW_LP] = carry_flag_i; end
                  OP_JZ:  begin ucode[CW_IO] = zero_flag_i;  ucode[CW_LP] = zero_flag_i;  end
                  OP_OUT: begin ucode[CW_AO] = 1'b1; ucode[CW_OI] = 1'b1; end
                  OP_HLT: ucode[CW_HLT] = 1'b1;
                  default: ;
               endcase
            end
            T3: begin
               unique case (opcode_i)
                  OP_LDA:         begin ucode[CW_RO] = 1'b1; ucode[CW_AI] = 1'b1; end
                  OP_ADD, OP_SUB: begin ucode[CW_RO] = 1'b1; ucode[CW_BI] = 1'b1; end
                  OP_STA:         begin ucode[CW_AO] = 1'b1; ucode[CW_RI] = 1'b1; end
                  default: ;
               endcase
            end
            T4: begin
               if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
                  ucode[CW_EO] = 1'b1;
                  ucode[CW_AI] = 1'b1;
                  ucode[CW_FI] = 1'b1;
                  ucode[CW_SU] = (opcode_i == OP_SUB);
               end
            end
            default: ;   // padding steps beyond T4 are idle
         endcase
      end
   end

   // Reset blanks every strobe in the cycle it is asserted.
   assign cw = rst_i ? '0 : ucode;

   always_comb begin
      state_d = state_q;
      if (state_q == ST_RUN && cw[CW_HLT]) state_d = ST_HALT;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_RUN;
      else       state_q <= state_d;
   end

   assign step_o = step_q;
   assign hlt_o  = cw[CW_HLT];
   assign mi_o   = cw[CW_MI];
   assign ri_o   = cw[CW_RI];
   assign ro_o   = cw[CW_RO];
   assign ii_o   = cw[CW_II];
   assign io_o   = cw[CW_IO];
   assign ai_o   = cw[CW_AI];
   assign ao_o   = cw[CW_AO];
   assign bi_o   = cw[CW_BI];
   assign eo_o   = cw[CW_EO];
   assign su_o   = cw[CW_SU];
   assign fi_o   = cw[CW_FI];
   assign oi_o   = cw[CW_OI];
   assign cp_o   = cw[CW_CP];
   assign ep_o   = cw[CW_EP];
   assign lp_o   = cw[CW_LP];

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Testbench for sap_control_sequencer: microcode-table reference model, directed and random scenarios.
// No ports.
module tb_sap_control_sequencer;

   localparam int NSTEPS = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic [3:0] opcode = 4'd0;
   logic       carry = 1'b0;
   logic       zero = 1'b0;
   logic [2:0] step_o;
   logic hlt_o, mi_o, ri_o, ro_o, ii_o, io_o, ai_o, ao_o, bi_o, eo_o, su_o, fi_o, oi_o, cp_o, ep_o, lp_o;

   int errors = 0;
   int checks = 0;

   // Reference model state: instruction step and halted flag
   int ms = 0;
   bit mh = 1'b0;

   string names [16] = '{"hlt","mi","ri","ro","ii","io","ai","ao","bi","eo","su","fi","oi","cp","ep","lp"};

   sap_control_sequencer #(.NUM_STEPS(NSTEPS)) dut (
      .clk_i(clk), .rst_i(rst), .run_i(run), .opcode_i(opcode),
      .carry_flag_i(carry), .zero_flag_i(zero), .step_o(step_o), .hlt_o(hlt_o),
      .mi_o(mi_o), .ri_o(ri_o), .ro_o(ro_o), .ii_o(ii_o), .io_o(io_o),
      .ai_o(ai_o), .ao_o(ao_o), .bi_o(bi_o), .eo_o(eo_o), .su_o(su_o),
      .fi_o(fi_o), .oi_o(oi_o), .cp_o(cp_o), .ep_o(ep_o), .lp_o(lp_o)
   );

   always #5 clk = ~clk;

   wire [18:0] obs = {step_o, hlt_o, mi_o, ri_o, ro_o, ii_o, io_o, ai_o, ao_o,
                      bi_o, eo_o, su_o, fi_o, oi_o, cp_o, ep_o, lp_o};

   // Microcode table in mnemonic form, straight from the instruction list
   function automatic string uops(int op, int t, bit c, bit z);
      if (t == 0) return "ep,mi";
      if (t == 1) return "ro,ii,cp";
      case (op)
         1:  if (t == 2) return "io,mi"; else if (t == 3) return "ro,ai";
         2:  if (t == 2) return "io,mi"; else if (t == 3) return "ro,bi"; else if (t == 4) return "eo,ai,fi";
         3:  if (t == 2) return "io,mi"; else if (t == 3) return "ro,bi"; else if (t == 4) return "eo,ai,su,fi";
         4:  if (t == 2) return "io,mi"; else if (t == 3) return "ao,ri";
         5:  if (t == 2) return "io,ai";
         6:  if (t == 2) return "io,lp";
         7:  if (t == 2 && c) return "io,lp";
         8:  if (t == 2 && z) return "io,lp";
         14: if (t == 2) return "ao,oi";
         15: if (t == 2) return "hlt";
         default: ;
      endcase
      return "";
   endfunction

   function automatic bit has(string list, string name);
      string s = {",", list, ","};
      string k = {",", name, ","};
      for (int i = 0; i + k.len() <= s.len(); i++)
         if (s.substr(i, i + k.len() - 1) == k) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [18:0] exp_vec();
      logic [18:0] e;
      string l;
      e = '0;
      e[18:16] = 3'(ms);
      if (rst)       l = "";
      else if (mh)   l = "hlt";
      else if (!run) l = "";
      else           l = uops(int'(opcode), ms, carry, zero);
      for (int i = 0; i < 16; i++) e[15-i] = has(l, names[i]);
      return e;
   endfunction

   task automatic drive(input bit r, input bit rn, input logic [3:0] op, input bit c, input bit z);
      rst = r; run = rn; opcode = op; carry = c; zero = z;
      #1;
   endtask

   // Advance one clock and step the model with the inputs held across that edge
   task automatic adv();
      @(posedge clk);
      if (rst) begin
         ms = 0; mh = 1'b0;
      end else if (!mh && run) begin
         if (ms == 2 && opcode == 4'hF) mh = 1'b1;
         else ms = (ms + 1) % NSTEPS;
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset cyc%0d: got %b want %b", i, obs, exp_vec());
         end
         checks++;
         if (obs !== 19'd0) begin
            errors++;
            $display("FAIL reset_zero cyc%0d: got %b want all zero", i, obs);
         end
         adv();
      end
   endtask

   task automatic test_opcode(input logic [3:0] op, input string tag);
      drive(1'b1, 1'b1, op, 1'b0, 1'b0); adv();
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b1, op, 1'($urandom), 1'($urandom));
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL %s cyc%0d: got %b want %b", tag, i, obs, exp_vec());
         end
         adv();
      end
   endtask

   task automatic test_jc();
      drive(1'b1, 1'b1, 4'h7, 1'b0, 1'b0); adv();
      for (int i = 0; i < 10; i++) begin
         // first instruction carry=0; second carry=1 except flipped low in T3
         drive(1'b0, 1'b1, 4'h7, (i >= 5) && (i != 8), 1'($urandom));
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL jc cyc%0d: got %b want %b", i, obs, exp_vec());
         end
         if (i == 7) begin
            checks++;
            if ({io_o, lp_o} !== 2'b11) begin
               errors++;
               $display("FAIL jc_taken: got io,lp=%b want 11", {io_o, lp_o});
            end
         end
         adv();
      end
   endtask

   task automatic test_halt();
      drive(1'b1, 1'b1, 4'hF, 1'b0, 1'b0); adv();
      for (int i = 0; i < 13; i++) begin
         if (i < 3) drive(1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
         else       drive(1'b0, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL halt cyc%0d: got %b want %b", i, obs, exp_vec());
         end
         if (i >= 2) begin
            checks++;
            if (obs !== {3'd2, 16'h8000}) begin
               errors++;
               $display("FAIL halt_frozen cyc%0d: got %b want step=2 hlt only", i, obs);
            end
         end
         adv();
      end
      drive(1'b1, 1'b1, 4'h1, 1'b0, 1'b0); adv();
      drive(1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
      checks++;
      if (obs !== {3'd0, 16'h4002}) begin
         errors++;
         $display("FAIL halt_exit: got %b want step=0 ep,mi", obs);
      end
      adv();
   endtask

   task automatic test_stall();
      bit pattern [9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
      drive(1'b1, 1'b1, 4'h2, 1'b0, 1'b0); adv();
      for (int i = 0; i < 9; i++) begin
         drive(1'b0, pattern[i], 4'h2, 1'($urandom), 1'($urandom));
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL stall cyc%0d: got %b want %b", i, obs, exp_vec());
         end
         adv();
      end
   endtask

   task automatic test_rst_mid();
      drive(1'b1, 1'b1, 4'h2, 1'b0, 1'b0); adv();
      for (int i = 0; i < 10; i++) begin
         if (i == 3) drive(1'b1, 1'b1, 4'h2, 1'b0, 1'b0);
         else        drive(1'b0, 1'b1, (i < 3) ? 4'h2 : 4'hA, 1'($urandom), 1'($urandom));
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL rst_mid cyc%0d: got %b want %b", i, obs, exp_vec());
         end
         adv();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 4'($urandom),
               1'($urandom), 1'($urandom));
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL random cyc%0d: op=%h run=%0d got %b want %b", i, opcode, run, obs, exp_vec());
         end
         checks++;
         if ((lp_o && cp_o) || ($countones({ep_o, ro_o, io_o, ao_o, eo_o}) > 1)) begin
            errors++;
            $display("FAIL invariant cyc%0d: got lp=%0d cp=%0d drivers=%b want exclusive", i, lp_o, cp_o,
                     {ep_o, ro_o, io_o, ao_o, eo_o});
         end
         adv();
      end
   endtask

   initial begin
      #1;
      adv();   // first reset edge brings the DUT to a known state
      test_reset();
      test_opcode(4'h1, "lda");
      test_opcode(4'h3, "sub");
      test_opcode(4'h2, "add");
      test_opcode(4'h4, "sta");
      test_opcode(4'hE, "out");
      test_jc();
      test_halt();
      test_stall();
      test_rst_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
